unidade_controle_multiciclo: RTL

//  Multicycle control FSM for the MIPS-subset datapath. Sequences fetch, decode,

---
 rtl/unidade_controle_multiciclo.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/write-back sequencing
// with Moore datapath selects, ready-handshake memory waits and a watchdog timeout.
module unidade_controle_multiciclo #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_pronta,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       parado,
  output logic       erro,
  output logic [3:0] estado
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] FN_JR   = 6'b001000;

  typedef enum logic [3:0] {
    BUSCA        = 4'd0,
    DECODIFICA   = 4'd1,
    EXEC_R       = 4'd2,
    ESCR_R       = 4'd3,
    CALC_END     = 4'd4,
    LE_MEM       = 4'd5,
    ESCR_MEM_REG = 4'd6,
    ESCREVE_MEM  = 4'd7,
    DESVIO       = 4'd8,
    SALTO        = 4'd9,
    EXEC_I       = 4'd10,
    ESCR_I       = 4'd11,
    JAL          = 4'd12,
    JR           = 4'd13,
    PARADO       = 4'd14,
    ERRO         = 4'd15
  } estado_t;

  estado_t       atual;
  estado_t       prox;
  logic [CW-1:0] espera;
  logic          em_espera;
  logic          estouro;

  assign em_espera = (atual == BUSCA) || (atual == LE_MEM) || (atual == ESCREVE_MEM);
  // mem_pronta in the final allowed cycle still wins over the watchdog
  assign estouro   = (TIMEOUT != 0) && em_espera && !mem_pronta &&
                     (espera == CW'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      atual  <= BUSCA;
      espera <= '0;
    end else begin
      atual <= prox;
      if (prox != atual) begin
        espera <= '0;
      end else if (em_espera && !mem_pronta) begin
        espera <= espera + CW'(1);
      end
    end
  end

  always_comb begin
    prox     = atual;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSource = 2'd0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 2'd0;
    RegDst   = 2'd0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUOp    = 2'd0;
    parado   = 1'b0;
    erro     = 1'b0;

    case (atual)
      BUSCA: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        if (mem_pronta) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          prox    = DECODIFICA;
        end else if (estouro) begin
          prox = ERRO;
        end
      end
      DECODIFICA: begin
        ALUSrcB = 2'd3;
        case (opcode)
          OP_R:          prox = (funct == FN_JR) ? JR : EXEC_R;
          OP_LW, OP_SW:  prox = CALC_END;
          OP_BEQ, OP_BNE: prox = DESVIO;
          OP_ADDI:       prox = EXEC_I;
          OP_J:          prox = SALTO;
          OP_JAL:        prox = JAL;
          OP_HALT:       prox = PARADO;
          default:       prox = ERRO;
        endcase
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd0;
        ALUOp   = 2'd2;
        prox    = ESCR_R;
      end
      ESCR_R: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
        prox     = BUSCA;
      end
      CALC_END: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        prox    = (opcode == OP_LW) ? LE_MEM : ESCREVE_MEM;
      end
      LE_MEM: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_pronta)   prox = ESCR_MEM_REG;
        else if (estouro) prox = ERRO;
      end
      ESCR_MEM_REG: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
        prox     = BUSCA;
      end
      ESCREVE_MEM: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_pronta)   prox = BUSCA;
        else if (estouro) prox = ERRO;
      end
      DESVIO: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'd1;
        PCSource = 2'd1;
        PCWrite  = zero ^ (opcode == OP_BNE);
        prox     = BUSCA;
      end
      SALTO: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        prox     = BUSCA;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        prox    = ESCR_I;
      end
      ESCR_I: begin
        RegWrite = 1'b1;
        prox     = BUSCA;
      end
      JAL: begin
        // ra captures PC+4 on the same edge that PC loads the jump target
        RegWrite = 1'b1;
        RegDst   = 2'd2;
        MemtoReg = 2'd2;
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        prox     = BUSCA;
      end
      JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'd3;
        prox     = BUSCA;
      end
      PARADO: parado = 1'b1;
      ERRO:   erro   = 1'b1;
      default: prox = ERRO;
    endcase

    // abandoned operations must not commit anything during the reset cycle
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign estado = atual;

endmodule
